dit_fft_8: RTL and testbench
============================

Name: dit_fft_8

Overview:
- 8-point radix-2 decimation-in-time FFT over a fixed set of eight real samples set by parameters.
- A 3-stage registered butterfly pipeline, advanced by the `new_clk` enable, fills an 8-entry complex result bank.
- `sel` chooses which bin is driven, registered, on `yr`/`yi`.
- Sits as a spectral test/demo engine in the audio path.

Parameters:
- X0..X7, default 0,1,2,3,4,5,6,7: signed 6-bit real input samples x[0..7]. Imaginary parts are 0.
- TW_C, default 91: Q7 twiddle constant for 0.7071 (cos/sin of pi/4).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- new_clk  input  1  pipeline advance enable; stages load only on edges where it is 1.
- sel  input  3  bin index k (0..7) to output.
- yr  output  9  signed real part of X[sel], registered.
- yi  output  9  signed imaginary part of X[sel], registered.

Behaviour:
- Reset (rst_n=0 at a clk edge): all stage registers, result bank, `yr` and `yi` become 0. Reset takes priority over `new_clk`.
- Internal arithmetic: signed, 12 bits; no overflow is possible internally for 6-bit inputs.
- Stage 1 (loads on a clk edge with new_clk=1), bit-reversed pairs (0,4),(2,6),(1,5),(3,7):
  - a0=x0+x4, a1=x0-x4
  - b0=x2+x6, b1=x2-x6
  - c0=x1+x5, c1=x1-x5
  - d0=x3+x7, d1=x3-x7
- Stage 2 (new_clk=1), W4^1=-j applied exactly:
  - E0=a0+b0, E2=a0-b0, E1=a1-j*b1, E3=a1+j*b1
  - O0=c0+d0, O2=c0-d0, O1=c1-j*d1, O3=c1+j*d1
- Stage 3 (new_clk=1), for k=0..3: X[k]=E_k+T_k, X[k+4]=E_k-T_k, where:
  - T0=O0
  - T2=-j*O2
  - T1: re=rnd(TW_C*(Or+Oi)), im=rnd(TW_C*(Oi-Or))
  - T3: re=rnd(TW_C*(Oi-Or)), im=rnd(-TW_C*(Or+Oi))
  - rnd(p)=(p+64)>>>7, arithmetic shift.
- Latency: the result bank holds the correct spectrum after the 3rd new_clk=1 edge following reset release.
  - The bank then stays constant while new_clk toggles, because the samples are constant.
  - With new_clk=0 every stage holds its value.
- Output: on every clk edge (independent of new_clk), yr/yi <= bank[sel] converted to 9 bits. Latency is 1 cycle from `sel`.
- `sel` may change every cycle; each value is honoured on the next edge.
- Reset mid-operation clears the pipeline, so the 3-edge fill restarts.

Optional Feature:
- Macro FFT_SAT_EN.
- Defined: 12-to-9-bit output conversion saturates to [-256,255].
- Undefined: conversion keeps the low 9 bits (two's-complement wrap).
- Default parameters never trigger either case.

Test Plan:
- Reset with new_clk=1, sel=0 -> yr=yi=0 during reset and until the bank fills. After 3 enabled edges plus 1 output edge: yr=28, yi=0.
- Sweep sel 0..7, one per cycle, after fill -> outputs one cycle later:
  - (28,0), (-4,10), (-4,4), (-4,2)
  - (-4,0), (-4,-2), (-4,-4), (-4,-10)
- new_clk=0 from reset release -> outputs stay 0 indefinitely. Raise new_clk -> the correct bin appears after 3+1 edges.
- Assert rst_n=0 mid-sweep -> yr/yi=0 on that edge, and the full refill latency is required again.
- Override X0..X7=1,0,0,0,0,0,0,0 -> every bin (1,0).
- Override X0..X7=31 (all) -> bin0=248. With FFT_SAT_EN, X0..X7=-32 -> bin0=-256; other bins (0,0).

Source files
------------

// File: rtl/dit_fft_8.sv
// 8-point radix-2 DIT FFT over eight constant real samples, 3-stage pipeline, one bin per cycle out.
// Optional macro FFT_SAT_EN: saturate the 12-to-9-bit output conversion instead of wrapping.
`timescale 1ns/1ps
module dit_fft_8 #(
    parameter logic signed [5:0] X0 = 6'sd0,
    parameter logic signed [5:0] X1 = 6'sd1,
    parameter logic signed [5:0] X2 = 6'sd2,
    parameter logic signed [5:0] X3 = 6'sd3,
    parameter logic signed [5:0] X4 = 6'sd4,
    parameter logic signed [5:0] X5 = 6'sd5,
    parameter logic signed [5:0] X6 = 6'sd6,
    parameter logic signed [5:0] X7 = 6'sd7,
    parameter int TW_C = 91
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              new_clk,
    input  logic [2:0]        sel,
    output logic signed [8:0] yr,
    output logic signed [8:0] yi
);
    localparam int unsigned DW = 12;
    localparam int unsigned PW = 24;
    localparam int unsigned OW = 9;

    typedef logic signed [DW-1:0] word_t;
    typedef logic signed [PW-1:0] prod_t;
    typedef logic signed [OW-1:0] out_t;

    localparam word_t XE0 = DW'(X0);
    localparam word_t XE1 = DW'(X1);
    localparam word_t XE2 = DW'(X2);
    localparam word_t XE3 = DW'(X3);
    localparam word_t XE4 = DW'(X4);
    localparam word_t XE5 = DW'(X5);
    localparam word_t XE6 = DW'(X6);
    localparam word_t XE7 = DW'(X7);
    localparam prod_t TWC = PW'(TW_C);

    // Q7 round-half-up back to working width
    function automatic word_t rnd(input prod_t p);
        return word_t'((p + PW'(64)) >>> 7);
    endfunction

    function automatic out_t to_out(input word_t v);
`ifdef FFT_SAT_EN
        if (v > DW'(255))       return OW'(255);
        else if (v < -DW'(256)) return OW'(-256);
        else                    return OW'(v);
`else
        return OW'(v);
`endif
    endfunction

    // stage registers: s1 pairs ordered (0,4),(2,6),(1,5),(3,7)
    word_t s1_sum [4], s1_dif [4];
    word_t e_re [4], e_im [4], o_re [4], o_im [4];
    word_t bk_re [8], bk_im [8];

    word_t n1_sum [4], n1_dif [4];
    word_t n2_ere [4], n2_eim [4], n2_ore [4], n2_oim [4];
    word_t n3_re [8], n3_im [8];
    word_t t_re [4], t_im [4];
    word_t sum1, dif1, sum3, dif3;

    always_comb begin
        n1_sum[0] = XE0 + XE4;  n1_dif[0] = XE0 - XE4;
        n1_sum[1] = XE2 + XE6;  n1_dif[1] = XE2 - XE6;
        n1_sum[2] = XE1 + XE5;  n1_dif[2] = XE1 - XE5;
        n1_sum[3] = XE3 + XE7;  n1_dif[3] = XE3 - XE7;
    end

    // W4^1 = -j is a swap/negate, so no multiplier is needed here
    always_comb begin
        n2_ere[0] = s1_sum[0] + s1_sum[1];  n2_eim[0] = '0;
        n2_ere[2] = s1_sum[0] - s1_sum[1];  n2_eim[2] = '0;
        n2_ere[1] = s1_dif[0];              n2_eim[1] = -s1_dif[1];
        n2_ere[3] = s1_dif[0];              n2_eim[3] = s1_dif[1];
        n2_ore[0] = s1_sum[2] + s1_sum[3];  n2_oim[0] = '0;
        n2_ore[2] = s1_sum[2] - s1_sum[3];  n2_oim[2] = '0;
        n2_ore[1] = s1_dif[2];              n2_oim[1] = -s1_dif[3];
        n2_ore[3] = s1_dif[2];              n2_oim[3] = s1_dif[3];
    end

    always_comb begin
        sum1 = o_re[1] + o_im[1];
        dif1 = o_im[1] - o_re[1];
        sum3 = o_re[3] + o_im[3];
        dif3 = o_im[3] - o_re[3];
        t_re[0] = o_re[0];
        t_im[0] = o_im[0];
        t_re[1] = rnd(TWC * PW'(sum1));
        t_im[1] = rnd(TWC * PW'(dif1));
        t_re[2] = o_im[2];
        t_im[2] = -o_re[2];
        t_re[3] = rnd(TWC * PW'(dif3));
        t_im[3] = rnd(-(TWC * PW'(sum3)));
        for (int k = 0; k < 4; k++) begin
            n3_re[k]     = e_re[k] + t_re[k];
            n3_im[k]     = e_im[k] + t_im[k];
            n3_re[k + 4] = e_re[k] - t_re[k];
            n3_im[k + 4] = e_im[k] - t_im[k];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                s1_sum[i] <= '0; s1_dif[i] <= '0;
                e_re[i]   <= '0; e_im[i]   <= '0;
                o_re[i]   <= '0; o_im[i]   <= '0;
            end
            for (int i = 0; i < 8; i++) begin
                bk_re[i] <= '0; bk_im[i] <= '0;
            end
        end else if (new_clk) begin
            s1_sum <= n1_sum; s1_dif <= n1_dif;
            e_re   <= n2_ere; e_im   <= n2_eim;
            o_re   <= n2_ore; o_im   <= n2_oim;
            bk_re  <= n3_re;  bk_im  <= n3_im;
        end
    end

    // bin readout runs every cycle regardless of new_clk
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            yr <= '0;
            yi <= '0;
        end else begin
            yr <= to_out(bk_re[sel]);
            yi <= to_out(bk_im[sel]);
        end
    end
endmodule

// File: tb/tb_dit_fft_8.sv
// Scoreboard bench for dit_fft_8: four parameterisations share controls; a monitor checks every queued bin.
`timescale 1ns/1ps
module tb_dit_fft_8;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       new_clk;
    logic [2:0] sel;
    logic signed [8:0] yr0, yi0, yr1, yi1, yr2, yi2, yr3, yi3;

    always #5 clk = ~clk;

    dit_fft_8 u_def (.clk(clk), .rst_n(rst_n), .new_clk(new_clk), .sel(sel), .yr(yr0), .yi(yi0));

    dit_fft_8 #(.X0(6'sd1), .X1(6'sd0), .X2(6'sd0), .X3(6'sd0),
                .X4(6'sd0), .X5(6'sd0), .X6(6'sd0), .X7(6'sd0))
        u_imp (.clk(clk), .rst_n(rst_n), .new_clk(new_clk), .sel(sel), .yr(yr1), .yi(yi1));

    dit_fft_8 #(.X0(6'sd31), .X1(6'sd31), .X2(6'sd31), .X3(6'sd31),
                .X4(6'sd31), .X5(6'sd31), .X6(6'sd31), .X7(6'sd31))
        u_max (.clk(clk), .rst_n(rst_n), .new_clk(new_clk), .sel(sel), .yr(yr2), .yi(yi2));

    dit_fft_8 #(.X0(6'sb100000), .X1(6'sb100000), .X2(6'sb100000), .X3(6'sb100000),
                .X4(6'sb100000), .X5(6'sb100000), .X6(6'sb100000), .X7(6'sb100000))
        u_neg (.clk(clk), .rst_n(rst_n), .new_clk(new_clk), .sel(sel), .yr(yr3), .yi(yi3));

    typedef struct {
        int    cyc;
        int    inst;
        int    re;
        int    im;
        string tag;
    } exp_t;

    exp_t sb[$];
    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    // hand-derived spectrum of x = 0..7
    int def_re [8] = '{28, -4, -4, -4, -4, -4, -4, -4};
    int def_im [8] = '{0, 10, 4, 2, 0, -2, -4, -10};

    task automatic drive(input logic r, input logic nc, input logic [2:0] s);
        @(negedge clk);
        rst_n   = r;
        new_clk = nc;
        sel     = s;
    endtask

    task automatic expect_bin(input int inst, input int re, input int im, input string tag);
        exp_t e;
        e.cyc  = cyc + 1;
        e.inst = inst;
        e.re   = re;
        e.im   = im;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic expect_zero(input string tag);
        for (int i = 0; i < 4; i++) expect_bin(i, 0, 0, tag);
    endtask

    task automatic expect_spec(input int k, input string tag);
        expect_bin(0, def_re[k], def_im[k], tag);
        expect_bin(1, 1, 0, tag);
        expect_bin(2, (k == 0) ? 248 : 0, 0, tag);
        expect_bin(3, (k == 0) ? -256 : 0, 0, tag);
    endtask

    // monitor: outputs are sampled 1ns after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            while (sb.size() != 0 && sb[0].cyc <= cyc) begin
                exp_t e;
                int gr;
                int gi;
                e = sb.pop_front();
                case (e.inst)
                    0:       begin gr = int'(yr0); gi = int'(yi0); end
                    1:       begin gr = int'(yr1); gi = int'(yi1); end
                    2:       begin gr = int'(yr2); gi = int'(yi2); end
                    default: begin gr = int'(yr3); gi = int'(yi3); end
                endcase
                vectors++;
                if (gr != e.re || gi != e.im) begin
                    miscompares++;
                    $display("FAIL %s inst%0d cyc%0d: got (%0d,%0d) expected (%0d,%0d)",
                             e.tag, e.inst, cyc, gr, gi, e.re, e.im);
                end
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        new_clk = 1'b1;
        sel     = 3'd0;

        repeat (3) begin drive(1'b0, 1'b1, 3'd0); expect_zero("reset"); end
        repeat (3) begin drive(1'b1, 1'b1, 3'd0); expect_zero("fill"); end
        drive(1'b1, 1'b1, 3'd0); expect_spec(0, "fill_done");

        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b1, 3'(k)); expect_spec(k, "sweep");
        end
        for (int k = 7; k >= 0; k--) begin
            drive(1'b1, 1'b0, 3'(k)); expect_spec(k, "hold");
        end

        drive(1'b1, 1'b1, 3'd0); expect_spec(0, "pre_reset");
        drive(1'b1, 1'b1, 3'd1); expect_spec(1, "pre_reset");
        drive(1'b0, 1'b1, 3'd2); expect_zero("mid_reset");
        repeat (3) begin drive(1'b1, 1'b1, 3'd3); expect_zero("refill"); end
        drive(1'b1, 1'b1, 3'd3); expect_spec(3, "refill_done");

        drive(1'b0, 1'b0, 3'd1); expect_zero("idle_reset");
        repeat (10) begin drive(1'b1, 1'b0, 3'd1); expect_zero("idle"); end
        repeat (3) begin drive(1'b1, 1'b1, 3'd1); expect_zero("wake"); end
        drive(1'b1, 1'b1, 3'd1); expect_spec(1, "wake_done");

        drive(1'b0, 1'b1, 3'd5); expect_zero("toggle_reset");
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, ((i % 2) == 0) ? 1'b1 : 1'b0, 3'd5); expect_zero("toggle");
        end
        drive(1'b1, 1'b0, 3'd5); expect_spec(5, "toggle_done");
        drive(1'b1, 1'b1, 3'd7); expect_spec(7, "toggle_done");

        drive(1'b1, 1'b1, 3'd0);
        drive(1'b1, 1'b1, 3'd0);
        drive(1'b1, 1'b1, 3'd0);
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
